// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, 5-9 data bits, 1-2 stop bits, valid/ready output
// with a one-entry holding register and overrun pulse. Optional parity is enabled by UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic                 rx_meta, rx_s;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 fe_acc;
`ifdef UART_RX_PARITY_EN
    logic                 pe_acc;
`endif

    logic tick, frame_done;
    assign tick       = (cnt == FULL_M1);
    assign frame_done = (state == STOP) && tick && (stop_idx == LAST_STOP);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift     <= '0;
            fe_acc    <= 1'b0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_acc     <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            overrun <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;  // start bit vanished: glitch
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                            fe_acc  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        cnt      <= '0;
                        pe_acc   <= (^shift) ^ rx_s ^ 1'(PARITY_ODD);
                        state    <= STOP;
                        stop_idx <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        cnt <= '0;
                        if (!rx_s) fe_acc <= 1'b1;
                        if (stop_idx == LAST_STOP) state <= IDLE;
                        else stop_idx <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A completing frame may overwrite the holding register only if it is empty or draining now.
            if (frame_done) begin
                if (!valid || ready) begin
                    data_out  <= shift;
                    frame_err <= fe_acc | ~rx_s;
`ifdef UART_RX_PARITY_EN
                    parity_err <= pe_acc;
`endif
                    valid     <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule
